digit_frame_tx: RTL and testbench

DIGIT_FRAME_TX -- requirements
Module: digit_frame_tx

---
 rtl/calc_pkg.sv | 29 ++
 rtl/uart_byte_tx.sv | 73 +++++++
 rtl/digit_frame_tx.sv | 219 +++++++++++++++++++++
 tb/tb_digit_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and encodings for the digit-entry frame transmitter.
package calc_pkg;

   // ASCII code of the character '0'; digit bytes are this plus the digit value
   localparam logic [7:0] ASCII_ZERO = 8'h30;

   // Frame controller states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_TERM,
      ST_DONE
   } ctrl_state_e;

   // Key action selected for the current cycle after edge qualification and priority
   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_CLEAR,
      ACT_BACK,
      ACT_DIGIT,
      ACT_SUBMIT
   } key_act_e;

   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      return ASCII_ZERO + {4'h0, d};
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, one stop bit.
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       txd
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

   logic          busy_q, busy_d;
   logic          txd_q, txd_d;
   logic [7:0]    shift_q, shift_d;
   logic [3:0]    bit_q, bit_d;
   logic [CW-1:0] tick_q, tick_d;

   // Next-state: accept a byte when idle, otherwise step through the ten bit periods
   always_comb begin
      busy_d  = busy_q;
      txd_d   = txd_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      tick_d  = tick_q;
      if (!busy_q) begin
         if (tx_start) begin
            busy_d  = 1'b1;
            txd_d   = 1'b0;
            shift_d = tx_data;
            bit_d   = '0;
            tick_d  = '0;
         end
      end else if (tick_q == LAST_TICK) begin
         tick_d = '0;
         if (bit_q == 4'd9) begin
            busy_d = 1'b0;
            txd_d  = 1'b1;
         end else begin
            // ones shifted in behind the data become the stop bit
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[7:1]};
            bit_d   = bit_q + 4'd1;
         end
      end else begin
         tick_d = tick_q + 1'b1;
      end
   end

   // Serializer registers; reset drops any byte in flight and idles the line high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= 1'b0;
         txd_q   <= 1'b1;
         shift_q <= '0;
         bit_q   <= '0;
         tick_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         txd_q   <= txd_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tick_q  <= tick_d;
      end
   end

   assign tx_busy = busy_q;
   assign txd     = txd_q;

endmodule

// File: rtl/digit_frame_tx.sv
// Keypad digit buffer that sends its contents as an ASCII frame over a UART line.
module digit_frame_tx
   import calc_pkg::*;
#(
   parameter int         DEPTH        = 8,
   parameter int         DISP         = 4,
   parameter int         CLKS_PER_BIT = 5208,
   parameter bit         TERM_EN      = 1'b1,
   parameter logic [7:0] TERM_CHAR    = 8'h0D
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [3:0]                   num,
   input  logic                         num_pressed,
   input  logic                         backspace,
   input  logic                         clear_all,
   input  logic                         submit,
   output logic [DISP*4-1:0]            disp,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         busy,
   output logic                         frame_done,
   output logic                         txd
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = $clog2(DEPTH);

   // slot 0 holds the newest digit
   logic [3:0]       slots_q [DEPTH];
   logic [3:0]       slots_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             complete_q, complete_d;
   logic             keys_low_q;

   ctrl_state_e      state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             term_q, term_d;

   key_act_e         act;
   logic             send_go;
   logic             any_key;

   logic             tx_start;
   logic [7:0]       tx_data;
   logic             tx_busy;

   assign any_key = num_pressed | backspace | clear_all | submit;

   // Remember whether every key was released last cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) keys_low_q <= 1'b0;
      else        keys_low_q <= ~any_key;
   end

   // Pick one action on the first key-high cycle after an all-released cycle, only when idle
   always_comb begin
      act = ACT_NONE;
      if (keys_low_q && (state_q == ST_IDLE)) begin
         if (clear_all)        act = ACT_CLEAR;
         else if (backspace)   act = ACT_BACK;
         else if (num_pressed) act = ACT_DIGIT;
         else if (submit)      act = ACT_SUBMIT;
      end
   end

   assign send_go = (act == ACT_SUBMIT) && (count_q != '0);

   // Buffer, count and flag updates for each key action
   always_comb begin
      slots_d    = slots_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      complete_d = complete_q;
      case (act)
         ACT_CLEAR: begin
            for (int unsigned i = 0; i < DEPTH; i++) slots_d[i] = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            complete_d = 1'b0;
         end
         ACT_BACK: begin
            if (count_q != '0) begin
               for (int unsigned i = 0; i < DEPTH - 1; i++) slots_d[i] = slots_q[i+1];
               slots_d[DEPTH-1] = '0;
               count_d    = count_q - 1'b1;
               complete_d = 1'b0;
            end
         end
         ACT_DIGIT: begin
            if (complete_q) begin
               // a sent frame is discarded by the first new digit
               for (int unsigned i = 0; i < DEPTH; i++) slots_d[i] = '0;
               slots_d[0] = num;
               count_d    = CNT_W'(1);
               complete_d = 1'b0;
            end else begin
               for (int unsigned i = 1; i < DEPTH; i++) slots_d[i] = slots_q[i-1];
               slots_d[0] = num;
               if (count_q == CNT_W'(DEPTH)) overflow_d = 1'b1;
               else                          count_d    = count_q + 1'b1;
            end
         end
         ACT_SUBMIT: begin
            if (count_q != '0) overflow_d = 1'b0;
         end
         default: ;
      endcase
      if (state_q == ST_DONE) complete_d = 1'b1;
   end

   // Buffer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) slots_q[i] <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         complete_q <= 1'b0;
      end else begin
         slots_q    <= slots_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         complete_q <= complete_d;
      end
   end

   // Controller state register, including the send index and terminator-sent flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         term_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         term_q  <= term_d;
      end
   end

   // Controller next state: walk slots from oldest (count-1) down to newest (0)
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      term_d  = term_q;
      case (state_q)
         ST_IDLE: begin
            if (send_go) begin
               state_d = ST_LOAD;
               idx_d   = IDX_W'(count_q - 1'b1);
               term_d  = 1'b0;
            end
         end
         ST_LOAD: if (!tx_busy) state_d = ST_WAIT;
         ST_WAIT: begin
            if (!tx_busy) begin
               if (term_q) begin
                  state_d = ST_DONE;
               end else if (idx_q != '0) begin
                  idx_d   = idx_q - 1'b1;
                  state_d = ST_LOAD;
               end else if (TERM_EN) begin
                  state_d = ST_TERM;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_TERM: begin
            if (!tx_busy) begin
               term_d  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Controller outputs decoded from the registered state
   always_comb begin
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
      tx_start   = 1'b0;
      tx_data    = '0;
      case (state_q)
         ST_LOAD: begin
            tx_start = ~tx_busy;
            tx_data  = digit_ascii(slots_q[idx_q]);
         end
         ST_TERM: begin
            tx_start = ~tx_busy;
            tx_data  = TERM_CHAR;
         end
         default: ;
      endcase
   end

   // Display the newest DISP slots, newest in the low nibble
   always_comb begin
      disp = '0;
      for (int unsigned i = 0; i < DISP; i++) disp[i*4 +: 4] = slots_q[i];
   end

   assign count    = count_q;
   assign overflow = overflow_q;

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk     (clk),
      .reset   (reset),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx_busy (tx_busy),
      .txd     (txd)
   );

endmodule

// File: tb/tb_digit_frame_tx.sv
// Self-checking bench for digit_frame_tx: queue-based model plus a UART line decoder.
module tb_digit_frame_tx;

   localparam int         DEPTH = 8;
   localparam int         DISP  = 4;
   localparam int         CPB   = 4;
   localparam logic [7:0] TERM  = 8'h0D;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [3:0]       num = '0;
   logic             kn = 1'b0, kb = 1'b0, kc = 1'b0, ks = 1'b0;
   logic [DISP*4-1:0] disp;
   logic [3:0]       count;
   logic             overflow, busy, frame_done, txd;

   digit_frame_tx #(
      .DEPTH(DEPTH), .DISP(DISP), .CLKS_PER_BIT(CPB), .TERM_EN(1'b1), .TERM_CHAR(TERM)
   ) dut (
      .clk(clk), .reset(rst_n), .num(num), .num_pressed(kn), .backspace(kb),
      .clear_all(kc), .submit(ks), .disp(disp), .count(count), .overflow(overflow),
      .busy(busy), .frame_done(frame_done), .txd(txd)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state: mq[0] is the newest digit
   logic [3:0] mq[$];
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   bit   m_ovf = 0, m_cmp = 0, m_busy = 0, m_prev_low = 0, fd_seen = 0, first_pending = 0;
   bit   m_any;
   time  fire_t = 0;
   int   fd_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model updated on the same clock edge the DUT samples keys
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete(); exp_q.delete();
         m_ovf = 0; m_cmp = 0; m_busy = 0; m_prev_low = 0; fd_seen = 0; first_pending = 0;
      end else begin
         m_any = kn | kb | kc | ks;
         if (m_busy) begin
            if (fd_seen) begin
               m_busy = 0; m_cmp = 1; fd_seen = 0;
            end
         end else if (m_any && m_prev_low) begin
            if (kc) begin
               mq.delete(); m_ovf = 0; m_cmp = 0;
            end else if (kb) begin
               if (mq.size() > 0) begin void'(mq.pop_front()); m_cmp = 0; end
            end else if (kn) begin
               if (m_cmp) begin mq.delete(); m_cmp = 0; end
               mq.push_front(num);
               if (mq.size() > DEPTH) begin void'(mq.pop_back()); m_ovf = 1; end
            end else if (ks) begin
               if (mq.size() > 0) begin
                  for (int i = mq.size() - 1; i >= 0; i--) exp_q.push_back(8'h30 + {4'h0, mq[i]});
                  exp_q.push_back(TERM);
                  m_ovf = 0; m_busy = 1; fire_t = $time; first_pending = 1;
               end
            end
         end
         m_prev_low = !m_any;
      end
   end

   // Per-cycle comparison of DUT outputs against the model
   initial begin
      logic [DISP*4-1:0] ed;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            ed = '0;
            for (int i = 0; i < DISP; i++) if (i < mq.size()) ed[i*4 +: 4] = mq[i];
            chk("disp", disp, ed);
            chk("count", count, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("busy", busy, m_busy);
            if (!m_busy) begin
               chk("frame_done_idle", frame_done, 0);
               chk("txd_idle", txd, 1);
            end else if (frame_done) begin
               fd_seen = 1; fd_cnt++;
            end
         end
      end
   end

   // UART line decoder: samples each bit at mid-period and checks bytes against the model
   initial begin
      bit         rx_on = 0;
      int         t = 0, k;
      logic [7:0] rb = '0;
      logic [31:0] ev;
      time        st = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rx_on = 0;
         end else if (!rx_on) begin
            if (txd === 1'b0) begin rx_on = 1; t = 0; st = $time; end
         end else begin
            t++;
            if (t % CPB == CPB / 2) begin
               k = t / CPB;
               if (k == 0) chk("start_bit", txd, 0);
               else if (k <= 8) rb[k-1] = txd;
               else begin
                  chk("stop_bit", txd, 1);
                  ev = (exp_q.size() > 0) ? {24'h0, exp_q.pop_front()} : 32'h100;
                  chk("rx_byte", rb, ev);
                  rx_log.push_back(rb);
                  if (first_pending) begin
                     chk("start_latency", (st - fire_t) <= 35, 1);
                     first_pending = 0;
                  end
                  rx_on = 0;
               end
            end
         end
      end
   end

   task automatic press(input logic n, input logic b, input logic c, input logic s,
                        input logic [3:0] v, input int hold);
      @(negedge clk);
      kn = n; kb = b; kc = c; ks = s; num = v;
      repeat (hold) @(negedge clk);
      kn = 0; kb = 0; kc = 0; ks = 0;
      @(negedge clk);
   endtask

   task automatic digit(input logic [3:0] v);
      press(1, 0, 0, 0, v, 1);
   endtask

   task automatic wait_frame();
      int n = 0;
      while (m_busy && n < 5000) begin @(negedge clk); n++; end
      if (m_busy) begin
         checks++; errors++;
         $display("FAIL frame_timeout: busy still set after %0d cycles", n);
      end
      chk("bytes_left", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic send_frame();
      int f0 = fd_cnt;
      rx_log.delete();
      press(0, 0, 0, 1, 0, 1);
      wait_frame();
      chk("frame_done_pulses", fd_cnt - f0, 1);
   endtask

   task automatic chk_log(input logic [7:0] e[$]);
      chk("frame_len", rx_log.size(), e.size());
      for (int i = 0; i < e.size(); i++)
         if (i < rx_log.size()) chk("frame_byte", rx_log[i], e[i]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] e[$];
      int op, hold;
      logic [3:0] v;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_disp", disp, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_txd", txd, 1);
      #2 rst_n = 1;
      repeat (2) @(negedge clk);

      // 1,2,3 then submit
      digit(1); digit(2); digit(3);
      chk("lit_disp_123", disp, 16'h0123);
      chk("lit_count_3", count, 3);
      send_frame();
      e = '{8'h31, 8'h32, 8'h33, 8'h0D};
      chk_log(e);
      chk("lit_disp_after", disp, 16'h0123);
      chk("lit_count_after", count, 3);

      // resend unchanged, then a new digit empties the buffer first
      send_frame();
      chk_log(e);
      digit(7);
      chk("lit_count_1", count, 1);
      chk("lit_disp_0007", disp, 16'h0007);

      // overflow with nine digits
      press(0, 0, 1, 0, 0, 1);
      for (int d = 1; d <= 9; d++) digit(4'(d));
      chk("lit_overflow", overflow, 1);
      chk("lit_count_8", count, 8);
      send_frame();
      e = '{8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0D};
      chk_log(e);
      chk("lit_overflow_cleared", overflow, 0);

      // backspace, and backspace on an empty buffer
      press(0, 0, 1, 0, 0, 1);
      digit(4); digit(5);
      press(0, 1, 0, 0, 0, 1);
      send_frame();
      e = '{8'h34, 8'h0D};
      chk_log(e);
      press(0, 0, 1, 0, 0, 1);
      press(0, 1, 0, 0, 0, 1);
      chk("lit_bs_empty", count, 0);
      rx_log.delete();
      press(0, 0, 0, 1, 0, 1);
      repeat (60) @(negedge clk);
      chk("lit_empty_submit", rx_log.size(), 0);

      // digit and clear rising together
      digit(3); digit(6);
      press(1, 0, 1, 0, 9, 1);
      chk("lit_clear_wins", count, 0);

      // submit held across the end of the frame must not resend
      digit(8);
      @(negedge clk); ks = 1;
      @(negedge clk);
      wait_frame();
      repeat (3) @(negedge clk);
      ks = 0;
      repeat (3) @(negedge clk);

      // randomized key traffic
      for (int it = 0; it < 80; it++) begin
         op = $urandom_range(0, 9);
         v = 4'($urandom_range(0, 9));
         hold = $urandom_range(1, 3);
         case (op)
            0, 1, 2, 3, 4, 5: press(1, 0, 0, 0, v, hold);
            6: press(0, 1, 0, 0, v, hold);
            7: press(0, 0, 1, 0, v, hold);
            8: press(0, 0, 0, 1, v, hold);
            default: press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v, hold);
         endcase
         if (m_busy) begin
            if ($urandom_range(0, 1) == 1) press(1, 1, 0, 0, v, 1);
            wait_frame();
         end
      end

      // reset in the middle of a byte; keys during busy are ignored
      press(0, 0, 1, 0, 0, 1);
      digit(5); digit(6);
      press(0, 0, 0, 1, 0, 1);
      repeat (12) @(negedge clk);
      press(1, 0, 0, 0, 2, 1);
      chk("busy_key_ignored", count, 2);
      #2 rst_n = 0;
      #1;
      chk("abort_txd", txd, 1);
      chk("abort_busy", busy, 0);
      chk("abort_count", count, 0);
      chk("abort_frame_done", frame_done, 0);
      @(negedge clk);
      #2 rst_n = 1;
      repeat (CPB * 12) @(negedge clk);
      chk("post_abort_txd", txd, 1);

      // recovery frame
      digit(0); digit(9);
      send_frame();
      e = '{8'h30, 8'h39, 8'h0D};
      chk_log(e);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
